// File: rtl/song_pkg.sv
// rtl/song_pkg.sv - shared types, ROM field layout and note display tables for the song sequencer
package song_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_e;

  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [3:0] NOTE_END  = 4'd15;
  localparam logic [3:0] NOTE_MAX  = 4'd12;

  localparam int NOTE_MSB = 15;
  localparam int NOTE_LSB = 12;
  localparam int OCT_MSB  = 11;
  localparam int OCT_LSB  = 10;
  localparam int DUR_MSB  = 9;
  localparam int DUR_LSB  = 0;

  // Index is code-1; sharps reuse the letter of the natural below them.
  localparam logic [6:0] SEG_TABLE [12] = '{
    7'h39, 7'h39, 7'h5E, 7'h5E, 7'h79, 7'h71,
    7'h71, 7'h3D, 7'h3D, 7'h77, 7'h77, 7'h7C
  };

  // Bit code-1 set for C#, D#, F#, G#, A#.
  localparam logic [11:0] SHARP_MASK = 12'h54A;

  function automatic logic note_is_pitch(input logic [3:0] code);
    return (code != NOTE_REST) && (code <= NOTE_MAX);
  endfunction

  function automatic logic [7:0] note_led(input logic [3:0] code);
    logic [7:0] seg;
    logic [3:0] idx;
    seg = 8'h00;
    idx = code - 4'd1;
    if (note_is_pitch(code)) begin
      seg[6:0] = SEG_TABLE[idx];
      seg[7]   = SHARP_MASK[idx];
    end
    return seg;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// rtl/ms_tick_gen.sv - millisecond tick divider driven by a runtime cycles-per-ms value
module ms_tick_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic [15:0] ticks_per_milli,
  output logic        tick
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic [15:0] limit;

  // >= rather than == so lowering the rate mid-count still ends the current ms.
  always_comb begin
    limit = (ticks_per_milli == 16'd0) ? 16'd0 : (ticks_per_milli - 16'd1);
    tick  = (cnt_q >= limit);
    cnt_d = cnt_q + 16'd1;
    if (clear || tick) begin
      cnt_d = 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// rtl/song_sequencer.sv - walks the song ROM, drives note/octave/gate and the note-letter LED
module song_sequencer
  import song_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int GAP_MS = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       ticks_per_milli,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [3:0]        note,
  output logic [1:0]        octave,
  output logic              gate,
  output logic [7:0]        led,
  output logic              busy,
  output logic              done
);

  localparam logic [9:0] GAP_LEN = 10'(GAP_MS);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [3:0]        note_q, note_d;
  logic [1:0]        octave_q, octave_d;
  logic [9:0]        ms_q, ms_d;
  logic              gate_q, gate_d;
  logic [7:0]        led_q, led_d;

  logic              tick;
  logic              tick_clear;
  logic [3:0]        code;
  logic [9:0]        dur;

  assign code = rom_data[NOTE_MSB:NOTE_LSB];
  assign dur  = rom_data[DUR_MSB:DUR_LSB];

  ms_tick_gen u_ms_tick (
    .clk             (clk),
    .rst_n           (rst_n),
    .clear           (tick_clear),
    .ticks_per_milli (ticks_per_milli),
    .tick            (tick)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rom_addr_d = rom_addr_q;
    note_d     = note_q;
    octave_d   = octave_q;
    ms_d       = ms_q;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          ptr_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        if (code == NOTE_END) begin
          if (loop_en) begin
            ptr_d   = '0;
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          note_d   = note_is_pitch(code) ? code : NOTE_REST;
          octave_d = rom_data[OCT_MSB:OCT_LSB];
          ms_d     = (dur == 10'd0) ? 10'd1 : dur;
          state_d  = S_PLAY;
        end
      end
      S_PLAY: begin
        if (tick) begin
          if (ms_q <= 10'd1) begin
            ptr_d = ptr_q + ADDR_W'(1);
            if (GAP_MS == 0) begin
              state_d = S_FETCH;
            end else begin
              ms_d    = GAP_LEN;
              state_d = S_GAP;
            end
          end else begin
            ms_d = ms_q - 10'd1;
          end
        end
      end
      S_GAP: begin
        if (tick) begin
          if (ms_q <= 10'd1) begin
            state_d = S_FETCH;
          end else begin
            ms_d = ms_q - 10'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (stop && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      ptr_d   = '0;
    end

    // Address is presented during FETCH so the ROM word is ready in LATCH.
    if (state_d == S_FETCH) begin
      rom_addr_d = ptr_d;
    end

    if (state_d == S_IDLE) begin
      note_d   = NOTE_REST;
      octave_d = 2'd0;
    end

    tick_clear = (state_d != state_q);
    gate_d     = (state_d == S_PLAY) && note_is_pitch(note_d);
    led_d      = gate_d ? note_led(note_d) : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      rom_addr_q <= '0;
      note_q     <= NOTE_REST;
      octave_q   <= 2'd0;
      ms_q       <= 10'd0;
      gate_q     <= 1'b0;
      led_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rom_addr_q <= rom_addr_d;
      note_q     <= note_d;
      octave_q   <= octave_d;
      ms_q       <= ms_d;
      gate_q     <= gate_d;
      led_q      <= led_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign note     = note_q;
  assign octave   = octave_q;
  assign gate     = gate_q;
  assign led      = led_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_song_sequencer.sv
// tb/tb_song_sequencer.sv - directed self-checking bench for song_sequencer
module tb_song_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] tpm;
  logic        start;
  logic        stop;
  logic        loop_en;
  logic [5:0]  rom_addr;
  logic [15:0] rom_data;
  logic [3:0]  note;
  logic [1:0]  octave;
  logic        gate;
  logic [7:0]  led;
  logic        busy;
  logic        done;

  logic [15:0] rom [64];
  int          nchecks = 0;
  int          nerr = 0;
  int          n;
  int          bad;

  always #5 clk = ~clk;

  song_sequencer #(.ADDR_W(6), .GAP_MS(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ticks_per_milli (tpm),
    .start           (start),
    .stop            (stop),
    .loop_en         (loop_en),
    .rom_addr        (rom_addr),
    .rom_data        (rom_data),
    .note            (note),
    .octave          (octave),
    .gate            (gate),
    .led             (led),
    .busy            (busy),
    .done            (done)
  );

  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_gate(output int cycles);
    cycles = 0;
    while (!gate && cycles < 400) begin
      step();
      cycles++;
    end
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 400) begin
      step();
      k++;
    end
    chk(tag, busy, 1'b0);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    loop_en = 1'b0;
    tpm     = 16'd4;
    for (int i = 0; i < 64; i++) rom[i] = 16'hF000;
    rom[0] = 16'h1003;
    step();
    step();
    chk("rst_gate", gate, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_led", led, 8'h00);
    chk("rst_addr", rom_addr, 6'd0);
    chk("rst_note_oct", {note, octave}, 6'd0);
    rst_n = 1'b1;
    step();

    // C, octave 0, 3 ms at 4 cycles/ms, then end marker
    pulse_start();
    wait_gate(n);
    chk("s1_latency", n + 1, 3);
    chk("s1_led", led, 8'h39);
    chk("s1_note", note, 4'd1);
    chk("s1_oct", octave, 2'd0);
    n = 0;
    bad = 0;
    while (gate && n < 200) begin
      if (led !== 8'h39) bad++;
      step();
      n++;
    end
    chk("s1_gate_len", n, 12);
    chk("s1_led_stable", bad, 0);
    chk("s1_led_off", led, 8'h00);
    n = 0;
    while (!done && n < 200) begin
      if (gate) bad++;
      step();
      n++;
    end
    chk("s1_fall_to_done", n, 10);
    chk("s1_gap_silent", bad, 0);
    step();
    chk("s1_done_once", done, 1'b0);
    chk("s1_busy_low", busy, 1'b0);

    // C# octave 1, 1 ms
    rom[0] = 16'h2401;
    pulse_start();
    wait_gate(n);
    chk("s2_led", led, 8'hB9);
    chk("s2_oct", octave, 2'd1);
    chk("s2_note", note, 4'd2);
    n = 0;
    while (gate && n < 200) begin
      step();
      n++;
    end
    chk("s2_gate_len", n, 4);
    wait_idle("s2_idle");

    // rest, 5 ms at one cycle per ms
    rom[0] = 16'h0005;
    tpm = 16'd1;
    pulse_start();
    n = 1;
    bad = 0;
    while (!done && n < 200) begin
      if (gate || led !== 8'h00 || note !== 4'd0) bad++;
      step();
      n++;
    end
    chk("s3_len", n, 12);
    chk("s3_silent", bad, 0);
    chk("s3_ptr", rom_addr, 6'd1);
    step();

    // looping playback, then stop mid-PLAY
    rom[0] = 16'h1003;
    tpm = 16'd4;
    loop_en = 1'b1;
    pulse_start();
    wait_gate(n);
    n = 0;
    while (gate && n < 200) begin
      step();
      n++;
    end
    chk("s4_first_len", n, 12);
    n = 0;
    bad = 0;
    while (!gate && n < 200) begin
      if (done) bad++;
      step();
      n++;
    end
    chk("s4_relaunch", n, 12);
    chk("s4_addr0", rom_addr, 6'd0);
    chk("s4_no_done", bad, 0);
    for (int i = 0; i < 5; i++) step();
    chk("s4_mid_play", gate, 1'b1);
    stop = 1'b1;
    step();
    chk("s4_stop_gate", gate, 1'b0);
    chk("s4_stop_busy", busy, 1'b0);
    chk("s4_stop_led", led, 8'h00);
    chk("s4_stop_note", note, 4'd0);
    chk("s4_stop_done", done, 1'b0);
    start = 1'b1;
    step();
    step();
    chk("s4_start_blocked", busy, 1'b0);
    start = 1'b0;
    stop = 1'b0;
    loop_en = 1'b0;
    step();

    // stop during the second entry, restart returns to entry 0
    rom[1] = 16'h5002;
    tpm = 16'd1;
    pulse_start();
    n = 0;
    while (!(gate && rom_addr == 6'd1) && n < 200) begin
      step();
      n++;
    end
    chk("s5_second_led", led, 8'h79);
    stop = 1'b1;
    step();
    chk("s5_stop_busy", busy, 1'b0);
    stop = 1'b0;
    pulse_start();
    chk("s5_restart_addr", rom_addr, 6'd0);
    wait_gate(n);
    chk("s5_restart_led", led, 8'h39);
    wait_idle("s5_idle");

    // T=0, zero durations, full table with no end marker
    tpm = 16'd0;
    for (int i = 0; i < 64; i++) rom[i] = 16'h1000;
    pulse_start();
    wait_gate(n);
    n = 0;
    while (gate && n < 200) begin
      step();
      n++;
    end
    chk("s6_gate_len", n, 1);
    n = 0;
    while (rom_addr != 6'd63 && n < 1000) begin
      step();
      n++;
    end
    chk("s6_reach_63", rom_addr, 6'd63);
    n = 0;
    while (rom_addr == 6'd63 && n < 100) begin
      step();
      n++;
    end
    chk("s6_wrap", rom_addr, 6'd0);
    chk("s6_still_busy", busy, 1'b1);
    wait_gate(n);
    chk("s6_in_play", gate, 1'b1);
    rst_n = 1'b0;
    step();
    chk("s6_rst_outputs", {gate, busy, done, led, note, octave, rom_addr}, 24'd0);
    rst_n = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
